// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART frame loader: FSM states, error codes and
// the default frame start marker.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR_H = 3'd1,
        ST_ADDR_L = 3'd2,
        ST_LEN_H  = 3'd3,
        ST_LEN_L  = 3'd4,
        ST_DATA   = 3'd5,
        ST_WRITE  = 3'd6,
        ST_CSUM   = 3'd7
    } state_e;

    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;

endpackage

// File: rtl/uart_loader_if.sv
// Byte-stream-in / memory-write-out signal bundle around the loader.
// Handshakes: a byte is offered on each rising edge of rx_valid; a memory
// write transfers on a cycle where mem_we and mem_ready are both high, and
// mem_we/mem_addr/mem_data hold steady until that cycle.
interface uart_loader_if;

    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        mem_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    // master: the environment (UART receiver plus memory); slave: the loader
    modport master (
        output rx_valid, rx_byte, mem_ready,
        input  mem_we, mem_addr, mem_data, busy, done, err, err_code
    );

    modport slave (
        input  rx_valid, rx_byte, mem_ready,
        output mem_we, mem_addr, mem_data, busy, done, err, err_code
    );

endinterface

// File: rtl/uart_loader.sv
// Parses SYNC/ADDR/LEN/payload/CSUM frames from a UART byte stream and writes
// the payload to memory, with checksum, overrun and inter-byte timeout checks.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int         CLKS_TIMEOUT = 120000,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int TW = (CLKS_TIMEOUT > 2) ? $clog2(CLKS_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(CLKS_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          rx_prev_q, rx_prev_d;
    logic [7:0]    acc_q, acc_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;

    logic          byte_acc;
    logic [7:0]    sum_next;
    logic          tmo_hit;

    always_comb begin
        state_d   = state_q;
        rx_prev_d = rx_valid;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = we_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        tmo_d     = tmo_q;
        tmo_hit   = 1'b0;
        byte_acc  = rx_valid && !rx_prev_q;
        sum_next  = acc_q + rx_byte;

        // The timer freezes during WRITE so a slow memory never times out a frame
        if (byte_acc || state_q == ST_IDLE) begin
            tmo_d = '0;
        end else if (state_q != ST_WRITE) begin
            if (tmo_q == TMO_LAST) tmo_hit = 1'b1;
            else                   tmo_d   = tmo_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (byte_acc && rx_byte == SYNC_BYTE) begin
                    acc_d   = 8'h00;
                    state_d = ST_ADDR_H;
                end
            end
            ST_ADDR_H: if (byte_acc) begin
                addr_d[15:8] = rx_byte;
                acc_d        = sum_next;
                state_d      = ST_ADDR_L;
            end
            ST_ADDR_L: if (byte_acc) begin
                addr_d[7:0] = rx_byte;
                acc_d       = sum_next;
                state_d     = ST_LEN_H;
            end
            ST_LEN_H: if (byte_acc) begin
                cnt_d[15:8] = rx_byte;
                acc_d       = sum_next;
                state_d     = ST_LEN_L;
            end
            ST_LEN_L: if (byte_acc) begin
                cnt_d   = {cnt_q[15:8], rx_byte};
                acc_d   = sum_next;
                state_d = (cnt_d != 16'h0000) ? ST_DATA : ST_CSUM;
            end
            ST_DATA: if (byte_acc) begin
                data_d  = rx_byte;
                acc_d   = sum_next;
                we_d    = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // A new byte before the write drains is an overrun, even if mem_ready is high
                if (byte_acc) begin
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    code_d  = ERR_OVERRUN;
                    state_d = ST_IDLE;
                end else if (mem_ready) begin
                    we_d    = 1'b0;
                    addr_d  = addr_q + 16'd1;
                    cnt_d   = cnt_q - 16'd1;
                    state_d = (cnt_q == 16'd1) ? ST_CSUM : ST_DATA;
                end
            end
            ST_CSUM: if (byte_acc) begin
                if (sum_next == 8'h00) begin
                    done_d = 1'b1;
                end else begin
                    err_d  = 1'b1;
                    code_d = ERR_CSUM;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (tmo_hit) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            tmo_d   = '0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rx_prev_q <= 1'b1;
            acc_q     <= 8'h00;
            cnt_q     <= 16'h0000;
            tmo_q     <= '0;
            addr_q    <= 16'h0000;
            data_q    <= 8'h00;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            rx_prev_q <= rx_prev_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    assign mem_we   = we_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = code_q;

endmodule
